wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter: BYPASS, default 1, enables same-cycle write-to-read byte bypass (0 = stored value only).
REQ-002 SHALL have port: clk  input  1  sole clock; all storage updates on posedge.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port: ALUShift_in  input  32  ALU/shifter result from the MEM/WB register.
REQ-005 SHALL have port: Data_in  input  32  memory load data from the MEM/WB register.
REQ-006 SHALL have port: Rd_write_by_en_in  input  4  per-byte write enables; bit i covers bits [8i+7:8i].
REQ-007 SHALL have port: Overflow_in  input  1  arithmetic overflow flag; suppresses the write.
REQ-008 SHALL have port: RegWr_in  input  1  register write request.
REQ-009 SHALL have port: MemtoReg_in  input  1  writeback source select (1 = Data_in, 0 = ALUShift_in).
REQ-010 SHALL have port: Rd_in  input  5  destination register index.
REQ-011 SHALL have ports: Ra_in, Rb_in  input  5  read port A/B register indices.
REQ-012 SHALL have ports: busA_out, busB_out  output  32  read port A/B data, combinational.
REQ-013 SHALL have port: Wr_data_out  output  32  selected writeback word, combinational, for forwarding.
REQ-014 SHALL have port: Wr_count_out  output  16  registered count of committed writes.

Function
REQ-015 Wr_data_out SHALL equal Data_in when MemtoReg_in=1, else ALUShift_in.
REQ-016 Effective write WE SHALL be RegWr_in & ~Overflow_in & (Rd_in!=0) & (Rd_write_by_en_in!=0) & Reset.
REQ-017 Storage SHALL be 31 x 32-bit registers (r1..r31); r0 SHALL have no storage and SHALL read 0 on both ports at all times.
REQ-018 On posedge clk with WE=1, each byte i of reg[Rd_in] with Rd_write_by_en_in[i]=1 SHALL take byte i of Wr_data_out; bytes with enable 0 SHALL be unchanged.
REQ-019 On posedge clk with WE=0, no register SHALL change.
REQ-020 Read ports SHALL be combinational with zero latency from Ra_in/Rb_in.
REQ-021 With BYPASS=1, WE=1 and Ra_in==Rd_in, busA_out byte i SHALL be the Wr_data_out byte when enable bit i=1, else the stored byte; likewise for port B with Rb_in.
REQ-022 With BYPASS=0, read ports SHALL return stored values only; the new value SHALL be visible the cycle after the commit edge.
REQ-023 Ra_in==Rb_in==Rd_in SHALL bypass identically on both ports.
REQ-024 Wr_count_out SHALL increment by 1 on each posedge with WE=1 and SHALL saturate at 16'hFFFF (no wrap).
REQ-025 Overflow_in=1 SHALL block the write and the count increment regardless of RegWr_in and enables.
REQ-026 Writes to Rd_in=0 SHALL be discarded and SHALL NOT increment Wr_count_out.

Reset
REQ-027 Reset=0 SHALL immediately, without a clock edge, clear r1..r31 to 0 and Wr_count_out to 0.
REQ-028 While Reset=0, no write SHALL occur and busA_out/busB_out SHALL read 0 (bypass disabled via REQ-016).
REQ-029 Reset asserted mid-operation SHALL discard any write at a coincident clock edge.
REQ-030 The first posedge after Reset returns to 1 SHALL be able to commit a write.

Verification
REQ-031 Full write: RegWr=1, en=4'hF, MemtoReg=0, ALUShift=32'hDEADBEEF, Rd=5 -> after edge, Ra=5 reads 32'hDEADBEEF; Wr_count_out=1.
REQ-032 Partial write: r5=32'hDEADBEEF, then MemtoReg=1, Data=32'h11223344, en=4'b0011, Rd=5 -> r5=32'hDEAD3344.
REQ-033 Suppression: Overflow=1, RegWr=1, en=4'hF, Rd=7, data 32'h1 -> r7 remains 0, count unchanged; Rd=0 write -> r0 reads 0, count unchanged.
REQ-034 Bypass: BYPASS=1, r9=0, WE to Rd=9 en=4'b1000 data 32'hAA000000, Ra=Rb=9 same cycle -> both buses 32'hAA000000 before the edge; BYPASS=0 -> 0 before, 32'hAA000000 after.
REQ-035 Reset: after several writes, drive Reset=0 between clock edges -> all reads 0 and Wr_count_out=0 at once; an edge with WE asserted during reset commits nothing.
REQ-036 Saturation: 65536 consecutive valid writes -> Wr_count_out=16'hFFFF and stays there on the next write.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 31 x 32-bit registers plus hardwired r0, byte-enabled writes,
// optional same-cycle write-to-read bypass, and a saturating count of committed writes.
module wb_regfile #(
   parameter bit BYPASS = 1'b1
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [31:0] ALUShift_in,
   input  logic [31:0] Data_in,
   input  logic [3:0]  Rd_write_by_en_in,
   input  logic        Overflow_in,
   input  logic        RegWr_in,
   input  logic        MemtoReg_in,
   input  logic [4:0]  Rd_in,
   input  logic [4:0]  Ra_in,
   input  logic [4:0]  Rb_in,
   output logic [31:0] busA_out,
   output logic [31:0] busB_out,
   output logic [31:0] Wr_data_out,
   output logic [15:0] Wr_count_out
);

   logic [31:0] regs_q [1:31];
   logic [31:0] rd_view [32];
   logic [15:0] count_q;
   logic        we;

   assign Wr_data_out  = MemtoReg_in ? Data_in : ALUShift_in;
   // Gating with Reset keeps the bypass path dark while reset is asserted.
   assign we           = RegWr_in & ~Overflow_in & (Rd_in != 5'd0) &
                         (Rd_write_by_en_in != 4'd0) & Reset;
   assign Wr_count_out = count_q;

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 1; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we) begin
         for (int i = 1; i < 32; i++) begin
            if (Rd_in == 5'(i)) begin
               for (int b = 0; b < 4; b++) begin
                  if (Rd_write_by_en_in[b]) begin
                     regs_q[i][8*b +: 8] <= Wr_data_out[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         count_q <= '0;
      end else if (we && count_q != 16'hFFFF) begin
         count_q <= count_q + 16'd1;
      end
   end

   // Full 32-entry read view with r0 tied to zero so read indices need no range guard.
   always_comb begin
      rd_view[0] = '0;
      for (int i = 1; i < 32; i++) begin
         rd_view[i] = regs_q[i];
      end
   end

   always_comb begin
      busA_out = rd_view[Ra_in];
      busB_out = rd_view[Rb_in];
      if (BYPASS && we) begin
         for (int b = 0; b < 4; b++) begin
            if (Rd_write_by_en_in[b]) begin
               if (Ra_in == Rd_in) begin
                  busA_out[8*b +: 8] = Wr_data_out[8*b +: 8];
               end
               if (Rb_in == Rd_in) begin
                  busB_out[8*b +: 8] = Wr_data_out[8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: bypass and non-bypass instances share stimulus and are
// compared against an array-based model of the register file.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        Reset;
   logic [31:0] ALUShift_in, Data_in;
   logic [3:0]  Rd_write_by_en_in;
   logic        Overflow_in, RegWr_in, MemtoReg_in;
   logic [4:0]  Rd_in, Ra_in, Rb_in;

   logic [31:0] busA_1, busB_1, wdata_1;
   logic [15:0] cnt_1;
   logic [31:0] busA_0, busB_0, wdata_0;
   logic [15:0] cnt_0;

   int total = 0;
   int bad   = 0;

   logic [31:0] mdl [32];
   int          mdl_cnt;

   always #5 clk = ~clk;

   wb_regfile #(.BYPASS(1'b1)) dut_byp (
      .clk(clk), .Reset(Reset), .ALUShift_in(ALUShift_in), .Data_in(Data_in),
      .Rd_write_by_en_in(Rd_write_by_en_in), .Overflow_in(Overflow_in), .RegWr_in(RegWr_in),
      .MemtoReg_in(MemtoReg_in), .Rd_in(Rd_in), .Ra_in(Ra_in), .Rb_in(Rb_in),
      .busA_out(busA_1), .busB_out(busB_1), .Wr_data_out(wdata_1), .Wr_count_out(cnt_1)
   );

   wb_regfile #(.BYPASS(1'b0)) dut_nobyp (
      .clk(clk), .Reset(Reset), .ALUShift_in(ALUShift_in), .Data_in(Data_in),
      .Rd_write_by_en_in(Rd_write_by_en_in), .Overflow_in(Overflow_in), .RegWr_in(RegWr_in),
      .MemtoReg_in(MemtoReg_in), .Rd_in(Rd_in), .Ra_in(Ra_in), .Rb_in(Rb_in),
      .busA_out(busA_0), .busB_out(busB_0), .Wr_data_out(wdata_0), .Wr_count_out(cnt_0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_wdata();
      return MemtoReg_in ? Data_in : ALUShift_in;
   endfunction

   function automatic bit exp_we();
      return RegWr_in && !Overflow_in && Rd_in != 0 && Rd_write_by_en_in != 0 && Reset;
   endfunction

   function automatic logic [31:0] exp_bus(input bit byp, input logic [4:0] idx);
      logic [31:0] v, wd;
      if (idx == 0) return 32'h0;
      v  = mdl[idx];
      wd = exp_wdata();
      if (byp && exp_we() && idx == Rd_in)
         for (int b = 0; b < 4; b++)
            if (Rd_write_by_en_in[b]) v[8*b +: 8] = wd[8*b +: 8];
      return v;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      mdl_cnt = 0;
   endfunction

   function automatic void model_commit();
      logic [31:0] wd;
      wd = exp_wdata();
      if (exp_we()) begin
         for (int b = 0; b < 4; b++)
            if (Rd_write_by_en_in[b]) mdl[Rd_in][8*b +: 8] = wd[8*b +: 8];
         if (mdl_cnt < 65535) mdl_cnt++;
      end
   endfunction

   // Called at a negedge with inputs already set; ends at the following negedge.
   task automatic cycle(input bit chk);
      #1;
      if (chk) begin
         check("wdata",   wdata_1, exp_wdata());
         check("busA_b1", busA_1,  exp_bus(1'b1, Ra_in));
         check("busB_b1", busB_1,  exp_bus(1'b1, Rb_in));
         check("busA_b0", busA_0,  exp_bus(1'b0, Ra_in));
         check("busB_b0", busB_0,  exp_bus(1'b0, Rb_in));
      end
      @(posedge clk);
      model_commit();
      #1;
      if (chk) begin
         check("cnt_b1", {16'h0, cnt_1}, mdl_cnt);
         check("cnt_b0", {16'h0, cnt_0}, mdl_cnt);
      end
      @(negedge clk);
   endtask

   task automatic set_wr(input bit wr, input bit ovf, input bit m2r, input logic [3:0] en,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] dat);
      RegWr_in = wr; Overflow_in = ovf; MemtoReg_in = m2r; Rd_write_by_en_in = en;
      Rd_in = rd; ALUShift_in = alu; Data_in = dat;
   endtask

   task automatic do_reset();
      #2;
      Reset = 1'b0;
      model_reset();
      #1;
      check("rst_cnt", {16'h0, cnt_1}, 32'h0);
      @(negedge clk);
      Reset = 1'b1;
   endtask

   initial begin
      Reset = 1'b0;
      model_reset();
      set_wr(0, 0, 0, 4'h0, 5'd0, 32'h0, 32'h0);
      Ra_in = 5'd0; Rb_in = 5'd0;
      #1;
      Ra_in = 5'd3;
      #1;
      check("reset_busA", busA_1, 32'h0);
      check("reset_cnt",  {16'h0, cnt_1}, 32'h0);
      @(negedge clk);
      Reset = 1'b1;

      // Full write to r5
      set_wr(1, 0, 0, 4'hF, 5'd5, 32'hDEADBEEF, 32'h0);
      Ra_in = 5'd5; Rb_in = 5'd0;
      cycle(1);
      set_wr(0, 0, 0, 4'h0, 5'd0, 32'h0, 32'h0);
      #1;
      check("full_wr", busA_0, 32'hDEADBEEF);
      check("full_cnt", {16'h0, cnt_0}, 32'd1);

      // Partial write from load data
      set_wr(1, 0, 1, 4'b0011, 5'd5, 32'h0, 32'h11223344);
      cycle(1);
      set_wr(0, 0, 0, 4'h0, 5'd0, 32'h0, 32'h0);
      #1;
      check("part_wr", busA_0, 32'hDEAD3344);

      // Overflow suppression and r0 discard
      set_wr(1, 1, 0, 4'hF, 5'd7, 32'h1, 32'h0);
      Ra_in = 5'd7;
      cycle(1);
      check("ovf_r7", busA_0, 32'h0);
      set_wr(1, 0, 0, 4'hF, 5'd0, 32'hFFFFFFFF, 32'h0);
      Ra_in = 5'd0; Rb_in = 5'd0;
      cycle(1);
      check("r0_cnt", {16'h0, cnt_1}, 32'd2);

      // Bypass on both ports to r9
      set_wr(1, 0, 0, 4'b1000, 5'd9, 32'hAA000000, 32'h0);
      Ra_in = 5'd9; Rb_in = 5'd9;
      #1;
      check("byp_A1", busA_1, 32'hAA000000);
      check("byp_B1", busB_1, 32'hAA000000);
      check("byp_A0", busA_0, 32'h0);
      cycle(1);
      set_wr(0, 0, 0, 4'h0, 5'd0, 32'h0, 32'h0);
      #1;
      check("byp_after", busB_0, 32'hAA000000);

      // Mid-cycle reset with write held asserted across an edge
      set_wr(1, 0, 0, 4'hF, 5'd9, 32'h12345678, 32'h0);
      #2;
      Reset = 1'b0;
      model_reset();
      #1;
      check("rst_busA", busA_1, 32'h0);
      check("rst_busB", busB_0, 32'h0);
      check("rst_cnt0", {16'h0, cnt_1}, 32'h0);
      @(posedge clk);
      #1;
      check("rst_edge_bus", busA_1, 32'h0);
      check("rst_edge_cnt", {16'h0, cnt_0}, 32'h0);
      @(negedge clk);
      Reset = 1'b1;
      cycle(1);
      check("post_rst_wr", busA_0, 32'h12345678);

      // Randomized traffic, occasional reset
      for (int n = 0; n < 1500; n++) begin
         set_wr($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1),
                4'($urandom), 5'($urandom), $urandom, $urandom);
         Ra_in = ($urandom_range(0, 3) == 0) ? Rd_in : 5'($urandom);
         Rb_in = ($urandom_range(0, 3) == 0) ? Rd_in : 5'($urandom);
         if ($urandom_range(0, 199) == 0) do_reset();
         else cycle(1);
      end

      // Saturation of the write counter
      do_reset();
      set_wr(1, 0, 0, 4'hF, 5'd1, 32'h0, 32'h0);
      Ra_in = 5'd1; Rb_in = 5'd2;
      for (int n = 0; n < 65534; n++) begin
         ALUShift_in = n;
         cycle(0);
      end
      check("cnt_fffe", {16'h0, cnt_1}, 32'h0000FFFE);
      cycle(1);
      check("cnt_ffff", {16'h0, cnt_1}, 32'h0000FFFF);
      cycle(1);
      check("cnt_hold", {16'h0, cnt_0}, 32'h0000FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
